// File: rtl/gate_test_pkg.sv
// Shared types and constants for the gate truth-table checker.
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Two-input truth tables; bit k is the gate output for input vector k.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int count_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that holds each stimulus vector for a fixed settle time.
module settle_timer
  import gate_test_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int W = count_width(SETTLE - 1);
  localparam logic [W-1:0] RELOAD = W'(SETTLE - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Walks every input vector through a combinational DUT, compares each settled
// output against a truth table and accumulates pass/fail results.
module gate_truth_checker
  import gate_test_pkg::*;
#(
  parameter int                 N_IN   = 2,
  parameter int                 SETTLE = 4,
  parameter logic [2**N_IN-1:0] EXPECT = TT_OR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            all_pass,
  output logic [N_IN:0]   pass_cnt,
  output logic [N_IN:0]   fail_cnt,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_t      state, next_state;
  logic        timer_load, timer_zero;
  logic        start_run;
  logic        match;
  logic [N_IN:0] fail_next;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (state == ST_SETTLE),
    .zero (timer_zero)
  );

  assign match     = (dut_y == EXPECT[stim]);
  assign fail_next = match ? fail_cnt : fail_cnt + (N_IN+1)'(1);
  assign busy      = (state == ST_SETTLE) || (state == ST_CHECK);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    start_run  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          next_state = ST_SETTLE;
          timer_load = 1'b1;
          start_run  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (timer_zero) next_state = ST_CHECK;
      end
      ST_CHECK: begin
        if (stim == LAST_VEC) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_SETTLE;
          timer_load = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Only the first mismatch of a run is latched; later ones just count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stim             <= '0;
      done             <= 1'b0;
      all_pass         <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (start_run) begin
      stim             <= '0;
      done             <= 1'b0;
      all_pass         <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (state == ST_CHECK) begin
      if (match) begin
        pass_cnt <= pass_cnt + (N_IN+1)'(1);
      end else begin
        fail_cnt <= fail_next;
        if (!first_fail_valid) begin
          first_fail_vec   <= stim;
          first_fail_valid <= 1'b1;
        end
      end
      if (stim == LAST_VEC) begin
        done     <= 1'b1;
        all_pass <= (fail_next == '0);
      end else begin
        stim <= stim + N_IN'(1);
      end
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker with a behavioural two-input gate as DUT.
module tb_gate_truth_checker;
  import gate_test_pkg::*;

  typedef struct {
    int mode;
    int exp_pass;
    int exp_fail;
    int exp_all_pass;
    int exp_ffv;
    int exp_ffvalid;
  } run_vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dut_y;
  logic [1:0] stim;
  logic       busy, done, all_pass;
  logic [2:0] pass_cnt, fail_cnt;
  logic [1:0] first_fail_vec;
  logic       first_fail_valid;

  int checks   = 0;
  int failures = 0;
  int dut_mode = 0;

  run_vec_t vecs [4];

  always #5 clk = ~clk;

  // Gate under test: 0=OR, 1=AND, 2=XOR, otherwise stuck-at-1.
  always_comb begin
    case (dut_mode)
      0:       dut_y = stim[0] | stim[1];
      1:       dut_y = stim[0] & stim[1];
      2:       dut_y = stim[0] ^ stim[1];
      default: dut_y = 1'b1;
    endcase
  end

  gate_truth_checker #(
    .N_IN   (2),
    .SETTLE (4),
    .EXPECT (TT_OR)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .dut_y            (dut_y),
    .stim             (stim),
    .busy             (busy),
    .done             (done),
    .all_pass         (all_pass),
    .pass_cnt         (pass_cnt),
    .fail_cnt         (fail_cnt),
    .first_fail_vec   (first_fail_vec),
    .first_fail_valid (first_fail_valid)
  );

  task automatic applyStimulus(input logic rst_v, input logic start_v);
    rst   = rst_v;
    start = start_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " stim"}, int'(stim), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " done"}, int'(done), 0);
    checkOutput({tag, " all_pass"}, int'(all_pass), 0);
    checkOutput({tag, " pass_cnt"}, int'(pass_cnt), 0);
    checkOutput({tag, " fail_cnt"}, int'(fail_cnt), 0);
    checkOutput({tag, " first_fail_vec"}, int'(first_fail_vec), 0);
    checkOutput({tag, " first_fail_valid"}, int'(first_fail_valid), 0);
  endtask

  task automatic checkResult(input string tag, input run_vec_t v);
    checkOutput({tag, " done"}, int'(done), 1);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " pass_cnt"}, int'(pass_cnt), v.exp_pass);
    checkOutput({tag, " fail_cnt"}, int'(fail_cnt), v.exp_fail);
    checkOutput({tag, " all_pass"}, int'(all_pass), v.exp_all_pass);
    checkOutput({tag, " first_fail_vec"}, int'(first_fail_vec), v.exp_ffv);
    checkOutput({tag, " first_fail_valid"}, int'(first_fail_valid), v.exp_ffvalid);
    checkOutput({tag, " stim_hold"}, int'(stim), 3);
  endtask

  // Edge 1 samples start; extra start pulses and a reset can be injected by edge number.
  task automatic runAndCheck(input string tag, input run_vec_t v, input int pulse_edge, input int rst_edge);
    int exp_stim;
    dut_mode = v.mode;
    for (int e = 1; e <= 21; e++) begin
      applyStimulus(e == rst_edge, (e == 1) || (e == pulse_edge));
      if (e == rst_edge) begin
        checkAllZero($sformatf("%s rst@%0d", tag, e));
        rst = 1'b0;
        return;
      end
      exp_stim = (e <= 5) ? 0 : (e <= 10) ? 1 : (e <= 15) ? 2 : 3;
      checkOutput($sformatf("%s stim@%0d", tag, e), int'(stim), exp_stim);
      checkOutput($sformatf("%s busy@%0d", tag, e), int'(busy), (e <= 20) ? 1 : 0);
      checkOutput($sformatf("%s done@%0d", tag, e), int'(done), (e >= 21) ? 1 : 0);
      if (e == 1) begin
        checkOutput({tag, " cleared pass_cnt"}, int'(pass_cnt), 0);
        checkOutput({tag, " cleared fail_cnt"}, int'(fail_cnt), 0);
        checkOutput({tag, " cleared ffvalid"}, int'(first_fail_valid), 0);
        checkOutput({tag, " cleared ffvec"}, int'(first_fail_vec), 0);
        checkOutput({tag, " cleared all_pass"}, int'(all_pass), 0);
      end
    end
    checkResult(tag, v);
  endtask

  initial begin
    vecs[0] = '{mode: 0, exp_pass: 4, exp_fail: 0, exp_all_pass: 1, exp_ffv: 0, exp_ffvalid: 0};
    vecs[1] = '{mode: 1, exp_pass: 2, exp_fail: 2, exp_all_pass: 0, exp_ffv: 1, exp_ffvalid: 1};
    vecs[2] = '{mode: 2, exp_pass: 3, exp_fail: 1, exp_all_pass: 0, exp_ffv: 3, exp_ffvalid: 1};
    vecs[3] = '{mode: 3, exp_pass: 3, exp_fail: 1, exp_all_pass: 0, exp_ffv: 0, exp_ffvalid: 1};

    rst   = 1'b1;
    start = 1'b0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkAllZero("reset");
    applyStimulus(1'b0, 1'b0);
    checkAllZero("idle");

    for (int i = 0; i < 4; i++) begin
      runAndCheck($sformatf("run%0d", i), vecs[i], 0, 0);
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);
      checkResult($sformatf("run%0d held", i), vecs[i]);
    end

    runAndCheck("midstart", vecs[0], 8, 0);

    runAndCheck("midrst", vecs[1], 0, 9);
    applyStimulus(1'b0, 1'b0);
    checkAllZero("after_rst idle");
    runAndCheck("post_rst", vecs[0], 0, 0);

    runAndCheck("repeatA", vecs[1], 0, 0);
    runAndCheck("repeatB", vecs[1], 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
